// File: rtl/psum_pkg.sv
// Shared types and default widths for the psum scratchpad address generator.
package psum_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_PASS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/psum_wrap_ptr.sv
// Scratchpad pointer that counts 0..lim and wraps back to 0; pulses wrap on the step at lim.
module psum_wrap_ptr
  import psum_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W-1:0] lim,
  output logic [ADDR_W-1:0] ptr,
  output logic              at_max,
  output logic              wrap
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign ptr    = ptr_q;
  assign at_max = (ptr_q == lim);
  assign wrap   = inc & at_max;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = at_max ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/psum_addr_gen.sv
// Psum spad address generator: write/read pointers, occupancy and multi-pass sequencing.
// Optional sticky overflow/underflow flags when PSUM_ADDR_ERR_EN is defined.
module psum_addr_gen
  import psum_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PASS_W = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              wr_at_max,
  output logic              rd_at_max,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              done
`ifdef PSUM_ADDR_ERR_EN
  ,
  output logic              ovf_err,
  output logic              udf_err
`endif
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;

  logic start_acc, restart, active, wr_wrap, last_wr;

  assign start_acc = (state_q == IDLE) & start & ~clear;
  assign restart   = clear | start_acc;
  // A clearing cycle accepts nothing, so its requests leave no trace after the clear.
  assign active    = ~clear & (state_q != IDLE);

  assign level = level_q;
  assign full  = (level_q == ({1'b0, lim_q} + LVL_W'(1)));
  assign empty = (level_q == '0);

  assign rd_ack = active & rd_en & ~empty;
  assign wr_ack = ~clear & (state_q == RUN) & wr_en & (~full | rd_ack);

  assign pass_cnt = pass_cnt_q;
  assign busy     = (state_q != IDLE);
  assign done     = ~clear & (state_q == DRAIN) & empty;
  assign last_wr  = wr_wrap & (pass_cnt_q == passes_q - PASS_W'(1));

  psum_wrap_ptr #(
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .inc    (wr_ack),
    .lim    (lim_q),
    .ptr    (wr_addr),
    .at_max (wr_at_max),
    .wrap   (wr_wrap)
  );

  psum_wrap_ptr #(
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .inc    (rd_ack),
    .lim    (lim_q),
    .ptr    (rd_addr),
    .at_max (rd_at_max),
    .wrap   ()
  );

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    passes_d   = passes_q;
    level_d    = level_q;
    pass_cnt_d = pass_cnt_q;

    if (clear) begin
      state_d  = IDLE;
      lim_d    = '0;
      passes_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = RUN;
            lim_d    = cfg_limit;
            passes_d = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
          end
        end
        RUN:     if (last_wr) state_d = DRAIN;
        DRAIN:   if (empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (restart) begin
      level_d    = '0;
      pass_cnt_d = '0;
    end else begin
      if (wr_ack & ~rd_ack) begin
        level_d = level_q + LVL_W'(1);
      end else if (rd_ack & ~wr_ack) begin
        level_d = level_q - LVL_W'(1);
      end
      if (wr_wrap && (pass_cnt_q != passes_q)) begin
        pass_cnt_d = pass_cnt_q + PASS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lim_q      <= '0;
      passes_q   <= '0;
      level_q    <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lim_q      <= lim_d;
      passes_q   <= passes_d;
      level_q    <= level_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

`ifdef PSUM_ADDR_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (restart) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_en & (((state_q == RUN) & full & ~rd_ack) | (state_q == DRAIN))) ovf_d = 1'b1;
      if (rd_en & empty & (state_q != IDLE)) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`endif

endmodule

// File: tb/tb_psum_addr_gen.sv
// Bench for psum_addr_gen: directed vector table, async-reset check, random run vs count model.
// Covers the error flags as well when PSUM_ADDR_ERR_EN is defined.
module tb_psum_addr_gen;

  localparam int AW = 5;
  localparam int PW = 4;
  localparam int OW = 3 * AW + 1 + PW + 8;

  logic          clk = 1'b0;
  logic          rst, clear, start, wr_en, rd_en;
  logic [AW-1:0] cfg_limit;
  logic [PW-1:0] cfg_passes;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ack, rd_ack, full, empty, wr_at_max, rd_at_max, busy, done;
  logic [AW:0]   level;
  logic [PW-1:0] pass_cnt;
`ifdef PSUM_ADDR_ERR_EN
  logic          ovf_err, udf_err;
`endif

  psum_addr_gen #(
    .ADDR_W (AW),
    .PASS_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .start      (start),
    .cfg_limit  (cfg_limit),
    .cfg_passes (cfg_passes),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .wr_ack     (wr_ack),
    .rd_ack     (rd_ack),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .wr_at_max  (wr_at_max),
    .rd_at_max  (rd_at_max),
    .pass_cnt   (pass_cnt),
    .busy       (busy),
    .done       (done)
`ifdef PSUM_ADDR_ERR_EN
    ,
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
`endif
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {wr_addr, rd_addr, level, pass_cnt, wr_ack, rd_ack, full, empty,
                wr_at_max, rd_at_max, busy, done};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of accepted writes/reads since the last start.
  int   m_nw, m_nr, m_lim, m_pass;
  bit   m_active;
  logic m_wack, m_rack, m_done;

  function automatic void model_reset();
    m_nw = 0; m_nr = 0; m_lim = 0; m_pass = 0; m_active = 0;
  endfunction

  function automatic logic [OW-1:0] model_eval();
    int  lp1, lvl, wa, ra;
    bit  running, draining, e, f;
    lp1      = m_lim + 1;
    lvl      = m_nw - m_nr;
    running  = m_active && (m_nw < m_pass * lp1);
    draining = m_active && !running;
    e        = (lvl == 0);
    f        = (lvl == lp1);
    m_rack   = !clear && m_active && rd_en && !e;
    m_wack   = !clear && running && wr_en && (!f || m_rack);
    m_done   = !clear && draining && e;
    wa       = m_nw % lp1;
    ra       = m_nr % lp1;
    return {AW'(wa), AW'(ra), (AW + 1)'(lvl), PW'(m_nw / lp1), m_wack, m_rack, f, e,
            wa == m_lim, ra == m_lim, m_active, m_done};
  endfunction

  function automatic void model_step();
    if (clear) begin
      model_reset();
    end else begin
      m_nw += int'(m_wack);
      m_nr += int'(m_rack);
      if (m_done) begin
        m_active = 0;
      end else if (!m_active && start) begin
        m_active = 1;
        m_lim    = int'(cfg_limit);
        m_pass   = (cfg_passes == 0) ? 1 : int'(cfg_passes);
        m_nw     = 0;
        m_nr     = 0;
      end
    end
  endfunction

  typedef struct {
    logic          clr, st;
    logic [AW-1:0] lim;
    logic [PW-1:0] pas;
    logic          we, re;
    logic [OW-9:0] pad;
    logic [2*AW+AW+1+PW+5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(int c, int s, int l, int p, int w, int r, int wack, int rack,
                              int wa, int ra, int lvl, int pc, int f, int e, int b, int d);
    vec_t v;
    v.clr = 1'(c); v.st = 1'(s); v.lim = AW'(l); v.pas = PW'(p); v.we = 1'(w); v.re = 1'(r);
    v.pad = '0;
    v.exp = {1'(wack), 1'(rack), AW'(wa), AW'(ra), (AW + 1)'(lvl), PW'(pc), 1'(f), 1'(e),
             1'(b), 1'(d)};
    tbl.push_back(v);
  endfunction

  logic [OW-1:0] rst_vec;

  // Drive one cycle: inputs after the edge, compare at the falling edge, advance the model.
  task automatic step(input logic c, input logic s, input logic [AW-1:0] l,
                      input logic [PW-1:0] p, input logic w, input logic r, input string name);
    clear = c; start = s; cfg_limit = l; cfg_passes = p; wr_en = w; rd_en = r;
    @(negedge clk);
    chk(name, obs, model_eval());
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst_vec = {AW'(0), AW'(0), (AW + 1)'(0), PW'(0), 8'b0001_1100};
    rst = 1'b1; clear = 0; start = 0; wr_en = 0; rd_en = 0; cfg_limit = '0; cfg_passes = '0;
    model_reset();
    @(negedge clk);
    chk("reset_state", obs, rst_vec);
    rst = 1'b0;
    @(posedge clk); #1;

    // clr st lim pas we re | wack rack waddr raddr level pass full empty busy done
    row(0,0,0,0,1,0, 0,0,0,0,0,0,0,1,0,0);
    row(0,1,3,2,0,0, 0,0,0,0,0,0,0,1,0,0);
    row(0,0,0,0,1,0, 1,0,0,0,0,0,0,1,1,0);
    row(0,0,0,0,1,0, 1,0,1,0,1,0,0,0,1,0);
    row(0,0,0,0,1,0, 1,0,2,0,2,0,0,0,1,0);
    row(0,0,0,0,1,0, 1,0,3,0,3,0,0,0,1,0);
    row(0,0,0,0,1,0, 0,0,0,0,4,1,1,0,1,0);
    row(0,0,0,0,1,1, 1,1,0,0,4,1,1,0,1,0);
    row(0,0,0,0,0,0, 0,0,1,1,4,1,1,0,1,0);
    row(0,0,0,0,0,1, 0,1,1,1,4,1,1,0,1,0);
    row(0,0,0,0,0,1, 0,1,1,2,3,1,0,0,1,0);
    row(0,0,0,0,0,1, 0,1,1,3,2,1,0,0,1,0);
    row(0,0,0,0,1,0, 1,0,1,0,1,1,0,0,1,0);
    row(0,0,0,0,1,0, 1,0,2,0,2,1,0,0,1,0);
    row(0,0,0,0,1,0, 1,0,3,0,3,1,0,0,1,0);
    row(0,0,0,0,1,0, 0,0,0,0,4,2,1,0,1,0);
    row(0,0,0,0,0,1, 0,1,0,0,4,2,1,0,1,0);
    row(0,0,0,0,0,1, 0,1,0,1,3,2,0,0,1,0);
    row(0,0,0,0,0,1, 0,1,0,2,2,2,0,0,1,0);
    row(0,0,0,0,0,1, 0,1,0,3,1,2,0,0,1,0);
    row(0,0,0,0,0,0, 0,0,0,0,0,2,0,1,1,1);
    row(0,0,0,0,0,0, 0,0,0,0,0,2,0,1,0,0);
    row(0,1,0,0,0,0, 0,0,0,0,0,2,0,1,0,0);
    row(0,0,0,0,1,1, 1,0,0,0,0,0,0,1,1,0);
    row(0,0,0,0,0,0, 0,0,0,0,1,1,1,0,1,0);
    row(0,0,0,0,1,1, 0,1,0,0,1,1,1,0,1,0);
    row(0,0,0,0,0,0, 0,0,0,0,0,1,0,1,1,1);
    row(0,0,0,0,0,0, 0,0,0,0,0,1,0,1,0,0);
    row(0,1,2,3,0,0, 0,0,0,0,0,1,0,1,0,0);
    row(0,0,0,0,1,0, 1,0,0,0,0,0,0,1,1,0);
    row(1,0,0,0,1,0, 0,0,1,0,1,0,0,0,1,0);
    row(0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0,0);

    foreach (tbl[i]) begin
      clear = tbl[i].clr; start = tbl[i].st; cfg_limit = tbl[i].lim; cfg_passes = tbl[i].pas;
      wr_en = tbl[i].we; rd_en = tbl[i].re;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {wr_ack, rd_ack, wr_addr, rd_addr, level, pass_cnt, full, empty, busy, done},
          tbl[i].exp);
      chk($sformatf("vec%0d_model", i), obs, model_eval());
      @(posedge clk);
      model_step();
      #1;
    end

    // Asynchronous reset in the middle of a run, with requests still asserted.
    step(0, 1, 5, 1, 0, 0, "arst_start");
    step(0, 0, 0, 0, 1, 0, "arst_wr0");
    step(0, 0, 0, 0, 1, 0, "arst_wr1");
    wr_en = 1; rd_en = 1;
    #2 rst = 1'b1;
    #1 chk("async_rst", obs, rst_vec);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef PSUM_ADDR_ERR_EN
    step(0, 1, 1, 1, 0, 0, "err_start");
    step(0, 0, 0, 0, 0, 1, "err_rd_empty");
    @(negedge clk) chk("udf_set", udf_err, 1);
    step(0, 0, 0, 0, 0, 0, "err_idle");
    chk("udf_held", udf_err, 1);
    step(1, 0, 0, 0, 0, 0, "err_clear");
    chk("udf_cleared", udf_err, 0);
    step(0, 1, 1, 1, 0, 0, "err_start2");
    step(0, 0, 0, 0, 1, 0, "err_wr0");
    chk("ovf_clean", ovf_err, 0);
    step(0, 0, 0, 0, 1, 0, "err_wr1");
    step(1, 0, 0, 0, 0, 0, "err_clear2");
    step(0, 1, 1, 2, 0, 0, "err_start3");
    step(0, 0, 0, 0, 1, 0, "err_wr2");
    step(0, 0, 0, 0, 1, 0, "err_wr3");
    step(0, 0, 0, 0, 1, 0, "err_wr_full");
    chk("ovf_set", ovf_err, 1);
    step(1, 0, 0, 0, 0, 0, "err_clear3");
`endif

    for (int i = 0; i < 4000; i++) begin
      logic          c, s, w, r;
      logic [AW-1:0] l;
      logic [PW-1:0] p;
      c = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 2)) : AW'($urandom);
      p = PW'($urandom_range(0, 3));
      w = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 40));
      r = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 70));
      step(c, s, l, p, w, r, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psum_addr_gen.md
Name: psum_addr_gen

Overview:
Parametrised psum scratchpad address generator with independent write and read pointers and an occupancy count. Supports a runtime entry limit and pass count. Sits beside the PE psum spad. Write side is fed by the MAC pipeline; read side by the psum forward/drain path. A small FSM sequences a multi-pass accumulation and signals completion.

Parameters:
ADDR_W, 5, pointer/address width; spad holds up to 2^ADDR_W entries
PASS_W, 4, width of the pass counter and cfg_passes

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear; same effect as reset, lower priority than rst
start  in  1  in IDLE, latch config and enter RUN; ignored elsewhere
cfg_limit  in  ADDR_W  last valid address (entries = cfg_limit+1); sampled on accepted start
cfg_passes  in  PASS_W  passes to run; 0 treated as 1; sampled on accepted start
wr_en  in  1  write request
rd_en  in  1  read request
wr_addr  out  ADDR_W  current write pointer
rd_addr  out  ADDR_W  current read pointer
wr_ack  out  1  comb: write accepted this cycle
rd_ack  out  1  comb: read accepted this cycle
level  out  ADDR_W+1  occupancy (accepted writes minus accepted reads)
full  out  1  level == lim+1
empty  out  1  level == 0
wr_at_max  out  1  wr_addr == lim
rd_at_max  out  1  rd_addr == lim
pass_cnt  out  PASS_W  completed write passes
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when DRAIN completes

Behaviour:
- Reset (rst high, async) and clear (sync):
  - Pointers, level, pass_cnt and latched lim/passes are 0.
  - done = 0, state = IDLE.
  - empty = 1, wr_at_max = rd_at_max = 1 (lim = 0); all other outputs 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. Latches lim = cfg_limit and passes = max(cfg_passes, 1). Zeroes pointers, level and pass_cnt.
  - RUN -> DRAIN on the accepted write at wr_addr == lim when pass_cnt == passes-1. pass_cnt increments to passes on the same edge.
  - DRAIN -> IDLE when empty. done pulses for exactly that one cycle.
- Acceptance:
  - IDLE: no requests accepted.
  - RUN: wr_ack = wr_en & (!full | rd_ack). rd_ack = rd_en & !empty.
  - DRAIN: wr_ack = 0. rd_ack = rd_en & !empty.
  - Full with simultaneous wr_en and rd_en: both accepted.
  - Empty with simultaneous wr_en and rd_en: write only.
- Pointer update: single-cycle latency; the address is visible the cycle after the ack.
  - An accepted op advances its pointer by 1.
  - At lim the pointer wraps to 0 (not to 2^ADDR_W).
  - Each accepted write at lim increments pass_cnt (saturating at passes).
- Level update: +1 on write-only, -1 on read-only, unchanged on both or neither. Never exceeds lim+1, never underflows.
- DRAIN entered with level 0: done pulses on the next cycle and the FSM returns to IDLE.
- lim = 0 (single entry): pointers remain 0; every accepted write is a wrap.
- clear mid-operation: aborts immediately, no done pulse.

Optional Feature:
Macro PSUM_ADDR_ERR_EN.
- Defined: adds outputs ovf_err and udf_err (1 bit each).
  - ovf_err: sticky; set by wr_en while full & !rd_ack in RUN, or by wr_en in DRAIN.
  - udf_err: sticky; set by rd_en while empty in RUN or DRAIN.
  - Both cleared only by rst, clear, or an accepted start.
- Undefined: ports absent; rejected requests are silently dropped.

Decomposition:
- Shared package psum_pkg holds:
  - state enum (IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2)
  - default ADDR_W/PASS_W localparams
- One natural sub-module: psum_wrap_ptr (ADDR_W-bit pointer with inc, lim, clear, wrap-pulse output). It is instantiated twice, once for write and once for read.
- Level, pass_cnt and the FSM stay in the top.

Test Plan:
- Reset/idle: assert rst mid-RUN -> all outputs return to reset values immediately; wr_en = 1 in IDLE gives wr_ack = 0 and wr_addr stays 0.
- Fill to full: start with cfg_limit = 3, cfg_passes = 2; 4 writes -> wr_addr 1,2,3,0, full = 1, level = 4, pass_cnt = 1; fifth write alone -> wr_ack = 0.
- Full with simultaneous ops: wr_en = rd_en = 1 while full -> both acked, level stays 4, rd_addr = 1, wr_addr = 1.
- Pass completion and drain: continue to the 8th accepted write -> DRAIN, pass_cnt = 2, further writes un-acked; read to empty -> done high for exactly 1 cycle, busy = 0 the next cycle.
- Empty edge and lim = 0: start with cfg_limit = 0; simultaneous wr+rd while empty -> write only, level = 1, wr_addr stays 0, pass_cnt = 1.
- With PSUM_ADDR_ERR_EN: rd_en while empty -> udf_err = 1 and held; clear -> 0; write while full -> ovf_err = 1.
